// File: rtl/qmult_pipe.sv
// -----------------------------------------------------------------------------
// qmult_pipe
//   Three-stage pipelined signed fixed-point multiplier. Operands and the
//   result are N-bit two's-complement words with Q fractional bits.
//   Each sample selects its own rounding mode. Overflow is reported per
//   sample and also accumulated into a sticky flag.
//
//   Optional build macro: QMULT_SAT_EN
//     defined   : an overflowed result saturates to +/-(2^(N-1)-1)
//     undefined : an overflowed result wraps (low N-1 magnitude bits, signed)
//
// Parameters
//   N  total word width (N >= 4)
//   Q  fractional bits (1 <= Q <= N-2)
//
// Ports
//   i_clk           clock, rising edge
//   i_rst           synchronous active-high reset
//   i_valid         input sample valid
//   o_ready         block can accept an input this cycle
//   i_multiplicand  operand A
//   i_multiplier    operand B
//   i_round         1 = round half away from zero, 0 = truncate toward zero
//   o_valid         o_result / o_ovr valid
//   i_ready         downstream accepts o_result
//   o_result        product
//   o_ovr           overflow for the sample on o_result
//   o_ovr_sticky    set by any transferred overflowed result
//   i_clr_ovr       clears o_ovr_sticky (a simultaneous set wins)
//
// Handshake: an input transfers on a cycle where i_valid && o_ready. An
// output transfers on a cycle where o_valid && i_ready. While
// o_valid && !i_ready (stall) every stage holds and o_ready is low.
// Otherwise all stages advance every cycle, and bubbles advance with them.
// -----------------------------------------------------------------------------
module qmult_pipe #(
  parameter int N = 32,
  parameter int Q = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_multiplicand,
  input  logic [N-1:0] i_multiplier,
  input  logic         i_round,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_result,
  output logic         o_ovr,
  output logic         o_ovr_sticky,
  input  logic         i_clr_ovr
);

  // Half an LSB of the result, expressed in product units.
  localparam logic [2*N:0] HALF_LSB = {{(2*N){1'b0}}, 1'b1} << (Q - 1);
  localparam logic [N-1:0] MAX_POS  = {1'b0, {(N-1){1'b1}}};

  logic stall;

  // Stage 1: sign and magnitudes
  logic         s1_valid;
  logic         s1_sign;
  logic [N-1:0] s1_mag_a;
  logic [N-1:0] s1_mag_b;
  logic         s1_round;

  // Stage 2: full unsigned product
  logic           s2_valid;
  logic           s2_sign;
  logic [2*N-1:0] s2_prod;
  logic           s2_round;

  // Stage 3 combinational result formation
  logic [2*N:0]   prod_rnd;
  logic [N-2:0]   res_mag;
  logic [N-1:0]   res_mag_ext;
  logic           res_ovr;
  logic [N-1:0]   res_signed;
  logic [N-1:0]   res_next;
  logic           unused_frac;

  assign stall   = o_valid & ~i_ready;
  assign o_ready = ~stall;

  // Rounding is applied before the range check, so a round-up into
  // 2^(N-1-Q) is reported as overflow.
  assign prod_rnd    = {1'b0, s2_prod} + (s2_round ? HALF_LSB : '0);
  assign res_mag     = prod_rnd[N-2+Q:Q];
  assign res_ovr     = |prod_rnd[2*N:N-1+Q];
  assign res_mag_ext = {1'b0, res_mag};
  // A negative sign with zero magnitude negates to 0, so no special case.
  assign res_signed  = s2_sign ? (-res_mag_ext) : res_mag_ext;

  // Fraction bits below the result LSB are dropped after rounding.
  assign unused_frac = ^prod_rnd[Q-1:0];

`ifdef QMULT_SAT_EN
  assign res_next = res_ovr ? (s2_sign ? (-MAX_POS) : MAX_POS) : res_signed;
`else
  assign res_next = res_signed;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid     <= 1'b0;
      s1_sign      <= 1'b0;
      s1_mag_a     <= '0;
      s1_mag_b     <= '0;
      s1_round     <= 1'b0;
      s2_valid     <= 1'b0;
      s2_sign      <= 1'b0;
      s2_prod      <= '0;
      s2_round     <= 1'b0;
      o_valid      <= 1'b0;
      o_result     <= '0;
      o_ovr        <= 1'b0;
      o_ovr_sticky <= 1'b0;
    end else begin
      if (!stall) begin
        // o_ready is high here, so i_valid alone marks an accepted sample.
        s1_valid <= i_valid;
        s1_sign  <= i_multiplicand[N-1] ^ i_multiplier[N-1];
        // -2^(N-1) negates to 2^(N-1), which fits exactly as N-bit unsigned.
        s1_mag_a <= i_multiplicand[N-1] ? (-i_multiplicand) : i_multiplicand;
        s1_mag_b <= i_multiplier[N-1]   ? (-i_multiplier)   : i_multiplier;
        s1_round <= i_round;

        s2_valid <= s1_valid;
        s2_sign  <= s1_sign;
        s2_prod  <= {{N{1'b0}}, s1_mag_a} * {{N{1'b0}}, s1_mag_b};
        s2_round <= s1_round;

        o_valid  <= s2_valid;
        o_result <= res_next;
        o_ovr    <= res_ovr;
      end

      // Set takes priority over clear.
      if (o_valid && i_ready && o_ovr) begin
        o_ovr_sticky <= 1'b1;
      end else if (i_clr_ovr) begin
        o_ovr_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qmult_pipe.sv
// -----------------------------------------------------------------------------
// tb_qmult_pipe
//   Self-checking bench for qmult_pipe with N=32, Q=16.
//   The driver tasks push the expected response into exp_q when a sample is
//   accepted. A forked monitor pops that queue and compares it on every
//   output transfer. The monitor also tracks the sticky flag and output
//   stability during stalls. Define QMULT_SAT_EN here as well when the DUT
//   is built with saturation.
// -----------------------------------------------------------------------------
module tb_qmult_pipe;

  localparam int N = 32;
  localparam int Q = 16;
  localparam int W = N + 1;   // {ovr, result}
`ifdef QMULT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_valid = 1'b0;
  logic         i_round = 1'b0;
  logic         i_ready = 1'b1;
  logic         i_clr_ovr = 1'b0;
  logic [N-1:0] i_multiplicand = '0;
  logic [N-1:0] i_multiplier = '0;
  logic         o_ready;
  logic         o_valid;
  logic [N-1:0] o_result;
  logic         o_ovr;
  logic         o_ovr_sticky;

  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail = 0;

  logic         sticky_m = 1'b0;
  logic         started = 1'b0;
  logic         prev_stall = 1'b0;
  logic         prev_ovr = 1'b0;
  logic [N-1:0] prev_res = '0;
  logic         rand_done = 1'b0;

  qmult_pipe #(.N(N), .Q(Q)) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_multiplicand (i_multiplicand),
    .i_multiplier   (i_multiplier),
    .i_round        (i_round),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_result       (o_result),
    .o_ovr          (o_ovr),
    .o_ovr_sticky   (o_ovr_sticky),
    .i_clr_ovr      (i_clr_ovr)
  );

  // ---------------- clock / watchdog ----------------
  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Real signed product, magnitude rounded/truncated to Q fraction bits.
  function automatic logic [W-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic rnd);
    longint p, m, lim;
    logic ovr;
    logic [N-1:0] r;
    p = longint'($signed(a)) * longint'($signed(b));
    m = (p < 0) ? -p : p;
    if (rnd) m = m + (longint'(1) << (Q - 1));
    m = m >> Q;
    lim = longint'(1) << (N - 1);
    ovr = (m >= lim);
    if (ovr && SAT) begin
      r = (p < 0) ? N'(-(lim - 1)) : N'(lim - 1);
    end else begin
      m = m % lim;
      r = (p < 0) ? N'(-m) : N'(m);
    end
    return {ovr, r};
  endfunction

  function automatic logic [N-1:0] rand_op();
    logic [N-1:0] corners[5];
    logic [N-1:0] v;
    corners = '{32'h80000000, 32'h7FFFFFFF, 32'h00000000, 32'h00010000, 32'hFFFF0000};
    case ($urandom_range(0, 3))
      0: v = $urandom();
      1: v = $urandom_range(0, 32'h001FFFFF) - 32'h00100000;
      2: v = corners[$urandom_range(0, 4)];
      default: v = $urandom_range(0, 32'h0007FFFF) - 32'h00040000;
    endcase
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Runs at every falling edge; outputs and inputs are stable there.
  task automatic monitor_step();
    logic [W-1:0] e;
    logic         e_ovr;
    if (i_rst) begin
      exp_q.delete();
      sticky_m   = 1'b0;
      prev_stall = 1'b0;
      started    = 1'b1;
    end else if (started) begin
      check("ovr_sticky", o_ovr_sticky, sticky_m);
      if (prev_stall) begin
        check("hold_valid", o_valid, 1);
        check("hold_result", o_result, prev_res);
        check("hold_ovr", o_ovr, prev_ovr);
      end
      if (o_valid && !i_ready) check("ready_in_stall", o_ready, 0);
      e_ovr = 1'b0;
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %0h expected no output (t=%0t)", o_result, $time);
        end else begin
          e = exp_q.pop_front();
          check("result", o_result, e[N-1:0]);
          check("ovr", o_ovr, e[N]);
          e_ovr = e[N];
        end
      end
      if (o_valid && i_ready && e_ovr) sticky_m = 1'b1;
      else if (i_clr_ovr)              sticky_m = 1'b0;
      prev_stall = o_valid && !i_ready;
      prev_res   = o_result;
      prev_ovr   = o_ovr;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic rnd,
                      input logic [W-1:0] e);
    bit done;
    done = 1'b0;
    i_multiplicand = a;
    i_multiplier   = b;
    i_round        = rnd;
    i_valid        = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (o_ready) begin
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    if (!done) fail_now("send_timeout");
  endtask

  task automatic send_model(input logic [N-1:0] a, input logic [N-1:0] b, input logic rnd);
    send(a, b, rnd, model(a, b, rnd));
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  // Right after a send() into an empty pipeline: valid exactly 3 cycles on.
  task automatic check_latency();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("latency_valid", o_valid, (k == 3) ? 1 : 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (o_valid) seen = 1'b1;
    end
    if (!seen) fail_now("wait_out_valid");
  endtask

  // ---------------- test sequence ----------------
  initial begin
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    // Reset state
    i_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b0;
    @(negedge clk);
    check("rst_valid", o_valid, 0);
    check("rst_result", o_result, 0);
    check("rst_ovr", o_ovr, 0);
    check("rst_ready", o_ready, 1);
    @(posedge clk);
    #1;

    // Basic products and latency
    send(32'h00018000, 32'h00020000, 1'b0, {1'b0, 32'h00030000});
    check_latency();
    send(32'hFFFE8000, 32'h00020000, 1'b0, {1'b0, 32'hFFFD0000});
    // Rounding
    send(32'h00000001, 32'h00008000, 1'b0, {1'b0, 32'h00000000});
    send(32'h00000001, 32'h00008000, 1'b1, {1'b0, 32'h00000001});
    send(32'h00000001, 32'hFFFF8000, 1'b1, {1'b0, 32'hFFFFFFFF});
    send(32'h00000001, 32'hFFFF8000, 1'b0, {1'b0, 32'h00000000});
    // Overflow
    send(32'h40000000, 32'h00040000, 1'b0, {1'b1, SAT ? 32'h7FFFFFFF : 32'h00000000});
    send(32'h80000000, 32'h00010000, 1'b0, {1'b1, SAT ? 32'h80000001 : 32'h00000000});
    // Negative sign, zero magnitude
    send(32'hFFFF0000, 32'h00000000, 1'b0, {1'b0, 32'h00000000});
    // Product 2^47-1: largest value under truncation, overflows on round-up
    send(32'h00A1E58F, 32'h00CA6691, 1'b0, {1'b0, 32'h7FFFFFFF});
    send(32'h00A1E58F, 32'h00CA6691, 1'b1, {1'b1, SAT ? 32'h7FFFFFFF : 32'h00000000});
    send(32'hFF5E1A71, 32'h00CA6691, 1'b0, {1'b0, 32'h80000001});
    drain();
    check("sticky_after_ovr", o_ovr_sticky, 1);

    // Sticky: clear alone, then clear coincident with an overflowed transfer
    i_clr_ovr = 1'b1;
    @(posedge clk);
    #1;
    i_clr_ovr = 1'b0;
    @(negedge clk);
    check("sticky_cleared", o_ovr_sticky, 0);
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    send(32'h40000000, 32'h00040000, 1'b0, {1'b1, SAT ? 32'h7FFFFFFF : 32'h00000000});
    wait_out_valid();
    check("sticky_before_xfer", o_ovr_sticky, 0);
    @(posedge clk);
    #1;
    i_clr_ovr = 1'b1;
    i_ready   = 1'b1;
    @(posedge clk);
    #1;
    i_clr_ovr = 1'b0;
    @(negedge clk);
    check("sticky_set_wins", o_ovr_sticky, 1);
    @(posedge clk);
    #1;
    i_clr_ovr = 1'b1;
    @(posedge clk);
    #1;
    i_clr_ovr = 1'b0;
    @(negedge clk);
    check("sticky_clr_alone", o_ovr_sticky, 0);
    @(posedge clk);
    #1;

    // Backpressure: 5 back-to-back, 2-cycle stall when the first is out
    fork
      begin
        for (int i = 0; i < 5; i++) send_model(rand_op(), rand_op(), 1'($urandom_range(0, 1)));
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
          @(posedge clk);
          #1;
          if (o_valid) seen = 1'b1;
        end
        if (!seen) fail_now("bp_first_out");
        i_ready = 1'b0;
        repeat (2) begin
          @(negedge clk);
          check("bp_ready_low", o_ready, 0);
          check("bp_valid_high", o_valid, 1);
          @(posedge clk);
        end
        #1;
        i_ready = 1'b1;
      end
    join
    drain();

    // Reset with 3 samples in flight
    send_model(32'h00020000, 32'h00030000, 1'b0);
    send_model(32'hFFF00000, 32'h00001234, 1'b1);
    send_model(32'h40000000, 32'h00040000, 1'b0);
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    @(negedge clk);
    check("post_reset_valid", o_valid, 0);
    check("post_reset_sticky", o_ovr_sticky, 0);
    @(posedge clk);
    #1;
    send(32'h00018000, 32'h00020000, 1'b0, {1'b0, 32'h00030000});
    check_latency();
    drain();

    // Randomised traffic with random backpressure and sticky clears
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send_model(rand_op(), rand_op(), 1'($urandom_range(0, 1)));
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          i_ready   = ($urandom_range(0, 3) != 0);
          i_clr_ovr = ($urandom_range(0, 15) == 0);
        end
      end
    join
    i_ready   = 1'b1;
    i_clr_ovr = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qmult_pipe.md
Name: qmult_pipe

Overview:
- Pipelined, parametrised signed fixed-point multiplier (QN-Q.Q format); successor to the combinational fixed-point multiplier used in datapath arithmetic.
- Adds registered stages, a valid/ready stream handshake with backpressure, per-sample round-or-truncate mode, and a sticky overflow flag.
- Sits between upstream datapath sources and accumulators/filters that need fixed-point products at full clock rate.

Parameters:
- N, 32, total word width in bits (two's complement); N >= 4
- Q, 16, fractional bits; 1 <= Q <= N-2

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  synchronous reset, active-high
- i_valid  in  1  input sample valid
- o_ready  out  1  block can accept an input this cycle
- i_multiplicand  in  N  signed Q-format operand A
- i_multiplier  in  N  signed Q-format operand B
- i_round  in  1  1 = round half away from zero, 0 = truncate toward zero; captured with the sample
- o_valid  out  1  o_result valid
- i_ready  in  1  downstream accepts o_result
- o_result  out  N  signed Q-format product
- o_ovr  out  1  overflow flag for the sample on o_result; qualified by o_valid
- o_ovr_sticky  out  1  set by any accepted overflowed output; cleared only by i_clr_ovr or reset
- i_clr_ovr  in  1  clears o_ovr_sticky

Behaviour:
- Reset: i_clk and i_rst are the only clock and reset. Reset is synchronous and active-high. On reset, all stage valids, o_valid, o_result, o_ovr and o_ovr_sticky go to 0. In-flight samples are discarded.
- Pipeline: three stages, latency 3 cycles from accept to o_valid when not stalled. Throughput is 1 sample per cycle.
- S1: register the sign as the XOR of the operand MSBs. Register the N-bit unsigned magnitudes. The magnitude of -2^(N-1) is 2^(N-1), held exactly. Register i_round.
- S2: form the 2N-bit unsigned product P = magA*magB.
- S3: if round, P' = P + 2^(Q-1) (2N+1 bits); otherwise P' = P. mag = P'[N-2+Q:Q]. ovr = OR of P'[2N:N-1+Q]. Result = sign ? -{0,mag} : {0,mag}.
- Rounding is applied before the overflow check. A round-up that reaches 2^(N-1-Q) therefore reports overflow.
- A negative sign with a zero magnitude yields 0.
- A product equal to -2^(N-1-Q) exactly (e.g. -32768*1.0) is flagged as overflow. The magnitude encoding cannot represent it.
- Handshake: stall = o_valid & ~i_ready. o_ready = ~stall.
  - An input is accepted when i_valid & o_ready.
  - While stalled, all stages hold, and o_result/o_ovr stay stable.
  - Bubbles (invalid stages) still advance when not stalled. No sample is lost or duplicated.
- Output transfer occurs when o_valid & i_ready.
- o_ovr_sticky: on a transfer with o_ovr=1, sticky is set. If i_clr_ovr and an overflowed transfer happen in the same cycle, set wins.
- i_rst mid-operation: the next cycle shows o_valid=0. The first new sample appears 3 cycles after its acceptance.

Optional Feature:
- QMULT_SAT_EN
- Defined: on ovr, o_result saturates to +(2^(N-1)-1), or -(2^(N-1)-1) when sign=1. o_ovr is still asserted.
- Not defined: wrap behaviour. o_result uses the low N-1 magnitude bits with the sign applied (legacy truncation), and o_ovr is still asserted.

Test Plan:
- N=32,Q=16, i_ready=1: 0x00018000*0x00020000, trunc -> o_result 0x00030000 three cycles after accept, o_ovr=0. Repeat with A=0xFFFE8000 -> 0xFFFD0000.
- Rounding: 0x00000001*0x00008000 -> trunc 0x00000000, round 0x00000001. Same operands with B=0xFFFF8000, round -> 0xFFFFFFFF.
- Overflow: 0x40000000*0x00040000 -> o_ovr=1, o_ovr_sticky=1. With QMULT_SAT_EN the result is 0x7FFFFFFF; without it, the result is 0x00000000. Then 0x80000000*0x00010000 -> o_ovr=1, and with SAT the result is 0x80000001.
- Backpressure: stream 5 back-to-back samples, drop i_ready for 2 cycles when the first is on the output. Required: o_ready=0 during the stall, o_result held, all 5 results delivered in order with correct values.
- Sticky flag: pulse i_clr_ovr in the same cycle as an overflowed transfer -> sticky stays 1. Pulse it alone next cycle -> sticky 0.
- Reset with 3 samples in flight, i_ready=1 -> o_valid=0 the cycle after reset and no stale output. Then one new sample -> result appears exactly 3 cycles after accept.
